// File: rtl/cpu_io_pkg.sv
// Shared CPU I/O definitions: UART register offsets, status bit positions, tx FSM states.
// No logic; constants and types only.
// Imported by the UART transmitter and its FIFO-facing glue.
package cpu_io_pkg;

  // Register offsets relative to the UART base word address
  localparam logic [15:0] UART_DATA_OFS = 16'd0;
  localparam logic [15:0] UART_STAT_OFS = 16'd1;

  // Status word bit positions
  localparam int STAT_EMPTY_BIT     = 0;
  localparam int STAT_FULL_BIT      = 1;
  localparam int STAT_TX_ACTIVE_BIT = 2;
  localparam int STAT_OVERFLOW_BIT  = 3;
  localparam int STAT_COUNT_LSB     = 4;
  localparam int STAT_COUNT_MSB     = 7;

  // Transmit FSM states; TX_PARITY is only reachable in parity builds
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Even parity of a data byte (XOR of all bits)
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU memory-port view of the UART: address/store strobe in, hit/read data out.
// Purely combinational signal bundle, no latency of its own.
// No backpressure: stores are always sampled, the UART decides to keep or drop them.
interface uart_tx_mmio_if;

  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        io_hit;
  logic [15:0] io_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  io_hit,
    input  io_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output io_hit,
    output io_rdata
  );

endinterface

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with registered pointers and an occupancy count.
// Latency: a pushed entry is visible at rdata the cycle after the push edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO can still accept when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: data register feeds a byte FIFO, status register reports it.
// Latency: store at edge N drives the start bit from edge N+2; bits last CLKS_PER_BIT cycles.
// Backpressure: none on the CPU; stores to a full FIFO are dropped and set sticky overflow.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit before the stop bit.
module uart_tx_mmio
  import cpu_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           busy
);

  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DATA_ADDR = BASE_ADDR + UART_DATA_OFS;
  localparam logic [15:0] STAT_ADDR = BASE_ADDR + UART_STAT_OFS;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  // Register decode
  logic hit_data;
  logic hit_stat;
  logic push_req;
  logic ovf_clr;

  // FIFO side
  logic             fifo_pop;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Transmitter state
  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        bit_end;
  logic        overflow_q;
  logic        tx_active;
  logic [15:0] status_word;

  // The upper store byte carries nothing for this block
  logic        unused_wdata_hi;
  assign unused_wdata_hi = ^bus.mem_wdata[15:8];

  assign hit_data = (bus.mem_addr == DATA_ADDR);
  assign hit_stat = (bus.mem_addr == STAT_ADDR);
  assign push_req = bus.mem_we && hit_data;
  assign ovf_clr  = bus.mem_we && hit_stat && bus.mem_wdata[3];

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (bus.mem_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_active = (state_q != TX_IDLE);
  assign busy      = tx_active || !fifo_empty;
  assign tx        = tx_q;
  assign bit_end   = (baud_q == BAUD_LAST);

  // Status word assembly; count is shown in a 4-bit field
  always_comb begin
    status_word = 16'h0000;
    status_word[STAT_EMPTY_BIT]                  = fifo_empty;
    status_word[STAT_FULL_BIT]                   = fifo_full;
    status_word[STAT_TX_ACTIVE_BIT]              = tx_active;
    status_word[STAT_OVERFLOW_BIT]               = overflow_q;
    status_word[STAT_COUNT_MSB:STAT_COUNT_LSB]   = 4'(fifo_count);
  end

  assign bus.io_hit   = hit_data || hit_stat;
  assign bus.io_rdata = hit_stat ? status_word : 16'h0000;

  // Sticky overflow: a store the FIFO could not take, cleared by software
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (push_req && fifo_full && !fifo_pop) begin
      overflow_q <= 1'b1;
    end else if (ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_q;

  // Parity of the byte in flight, captured when it leaves the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (fifo_pop) begin
      par_q <= even_parity(fifo_rdata);
    end
  end
`endif

  // Next-state, baud/bit bookkeeping and the line level for the next cycle
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = 1'b1;
    fifo_pop = 1'b0;

    if (state_q != TX_IDLE) begin
      baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
    end

    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          idx_d    = 3'd0;
          baud_d   = 16'd0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        tx_d = par_q;
        if (bit_end) begin
          state_d = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          // Chain straight into the next start bit when more data is waiting
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            idx_d    = 3'd0;
            state_d  = TX_START;
          end else begin
            state_d  = TX_IDLE;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; tx is registered so the line never glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q  <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed register/timing steps plus random traffic.
// A line-level UART receiver decodes tx and is compared against a queue of stored bytes.
module tb_uart_tx_mmio;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;
  localparam logic [15:0] DATA_A = 16'hFF00;
  localparam logic [15:0] STAT_A = 16'hFF01;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  logic busy;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .BASE_ADDR    (16'hFF00),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- line-level receiver ----------------
  int         cyc = 0;
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         rx_err = 0;
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_bits = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Sample each bit in its middle, counted from the first low sample of the start bit
  always @(negedge clk) begin
    if (rst) begin
      rx_on <= 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on  <= 1'b1;
        rx_cnt <= 1;
        start_q.push_back(cyc);
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt % CPB == CPB / 2) begin
        if (rx_cnt / CPB == 0) begin
          if (tx !== 1'b0) rx_err <= rx_err + 1;
        end else if (rx_cnt / CPB <= 8) begin
          rx_bits[rx_cnt / CPB - 1] <= tx;
        end else if (rx_cnt / CPB == NBITS - 1) begin
          if (tx !== 1'b1) rx_err <= rx_err + 1;
          rx_q.push_back(rx_bits);
          rx_on <= 1'b0;
        end else begin
          if (tx !== ^rx_bits) rx_err <= rx_err + 1;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_we    = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d, output logic h);
    bus.mem_addr = a;
    #1;
    d = bus.io_rdata;
    h = bus.io_hit;
    bus.mem_addr = 16'h0000;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((busy || rx_on) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_drain_in_time"}, 32'(n < budget), 32'd1);
    repeat (2) cycle();
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_rx_count"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      chk($sformatf("%s_rx_byte%0d", tag, i), rx_q[i], exp[i]);
    end
    rx_q.delete();
  endtask

  // Expected line level e edges after the store edge of a lone byte
  function automatic logic line_exp(input int e, input logic [7:0] b);
    int rel;
    int bitn;
    rel = e - 2;
    if (rel < 0 || rel >= FRAME) return 1'b1;
    bitn = rel / CPB;
    if (bitn == 0) return 1'b0;
    if (bitn <= 8) return b[bitn - 1];
    if (NBITS == 11 && bitn == 9) return ^b;
    return 1'b1;
  endfunction

  // Status word built from its fields
  function automatic logic [15:0] stat(input int cnt, input bit ovf, input bit act);
    return {8'h00, 4'(cnt), ovf, act, (cnt == DEPTH), (cnt == 0)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, observed hang expected finish");
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] d;
    logic        h;
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    int          n;
    int          timeouts;

    bus.mem_addr  = 16'h0000;
    bus.mem_wdata = 16'h0000;
    bus.mem_we    = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and decode
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    rd(STAT_A, d, h);
    chk("rst_status", d, 16'h0001);
    chk("rst_stat_hit", h, 1'b1);
    rd(DATA_A, d, h);
    chk("data_read_zero", d, 16'h0000);
    chk("data_read_hit", h, 1'b1);
    rd(16'hFF02, d, h);
    chk("miss_hit", h, 1'b0);
    chk("miss_rdata", d, 16'h0000);

    // Single byte: cycle-exact line and busy
    store(DATA_A, 16'h0055);
    for (int e = 0; e <= FRAME + 4; e++) begin
      chk($sformatf("single_tx_e%0d", e), tx, line_exp(e, 8'h55));
      chk($sformatf("single_busy_e%0d", e), busy, 32'(e <= FRAME));
      cycle();
    end
    drain("single", 200);
    exp_q = '{8'h55};
    check_rx("single", exp_q);

    // Back-to-back frames
    start_q.delete();
    store(DATA_A, 16'h00A1);
    store(DATA_A, 16'h00B2);
    drain("b2b", 4 * FRAME);
    exp_q = '{8'hA1, 8'hB2};
    check_rx("b2b", exp_q);
    chk("b2b_starts", start_q.size(), 2);
    if (start_q.size() == 2) chk("b2b_gap", start_q[1] - start_q[0], FRAME);

    // Full FIFO with a store on the pop edge
    for (int i = 0; i < 5; i++) store(DATA_A, 16'(8'h10 + i));
    rd(STAT_A, d, h);
    chk("full_status", d, stat(4, 1'b0, 1'b1));
    repeat (FRAME - 4) cycle();
    store(DATA_A, 16'h0015);
    rd(STAT_A, d, h);
    chk("pushpop_status", d, stat(4, 1'b0, 1'b1));
    drain("pushpop", 8 * FRAME);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    check_rx("pushpop", exp_q);

    // Overflow and its clear; out-of-range store has no effect
    for (int i = 0; i < 6; i++) store(DATA_A, 16'(8'h20 + i));
    rd(STAT_A, d, h);
    chk("ovf_status", d, stat(4, 1'b1, 1'b1));
    store(STAT_A, 16'h00F7);
    rd(STAT_A, d, h);
    chk("ovf_kept_bit3_low", d, stat(4, 1'b1, 1'b1));
    store(STAT_A, 16'h0008);
    rd(STAT_A, d, h);
    chk("ovf_cleared", d, stat(4, 1'b0, 1'b1));
    store(16'hFF05, 16'h0033);
    rd(STAT_A, d, h);
    chk("miss_store_no_effect", d, stat(4, 1'b0, 1'b1));
    drain("ovf", 8 * FRAME);
    exp_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    check_rx("ovf", exp_q);

    // Reset during data bit 3 of a frame with another byte queued
    store(DATA_A, 16'h0055);
    store(DATA_A, 16'h0077);
    repeat (17) cycle();
    chk("midrst_pre_tx", tx, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    rd(STAT_A, d, h);
    chk("midrst_status", d, 16'h0001);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rx_q.delete();
    cycle();
    chk("midrst_after_busy", busy, 1'b0);
    store(DATA_A, 16'h00C3);
    drain("midrst", 4 * FRAME);
    exp_q = '{8'hC3};
    check_rx("midrst", exp_q);

    // Random bytes at random spacing, waiting on full before each store
    exp_q.delete();
    timeouts = 0;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, FRAME)) cycle();
      n = 0;
      rd(STAT_A, d, h);
      while (d[1] && n < 500) begin
        cycle();
        rd(STAT_A, d, h);
        n++;
      end
      if (n >= 500) timeouts++;
      store(DATA_A, {8'h00, b});
      exp_q.push_back(b);
    end
    chk("rand_wait_timeouts", timeouts, 0);
    drain("rand", 20 * FRAME);
    check_rx("rand", exp_q);
    rd(STAT_A, d, h);
    chk("rand_final_status", d, 16'h0001);
    chk("frame_errors", rx_err, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
